// File: rtl/jt51_pkg.sv
// Shared types for the JT51 host write path.
// FSM encoding and the queued (address, data) entry.
package jt51_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GAP,
      ST_DATA,
      ST_WAIT_HI,
      ST_WAIT_LO
   } wrq_state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } jt51_entry_t;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// Single-clock FIFO of register writes.
// First-word-fall-through head, flush clears everything.
module jt51_wrq_fifo
   import jt51_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  jt51_entry_t   wr_entry,
   input  logic          pop,
   output jt51_entry_t   head,
   output logic [LW-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   jt51_entry_t    mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && (level != LW'(DEPTH)) && !flush;
   assign do_pop  = pop && (level != '0) && !flush;
   assign head    = mem[rd_ptr];

   // storage array, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   // pointers and occupancy; pointers wrap as DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/jt51_wrq.sv
// Host write queue in front of the JT51 register block.
// Replays queued pairs as a0=0/a0=1 strobes paced on busy.
module jt51_wrq
   import jt51_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int LW      = $clog2(DEPTH) + 1,
   parameter int BUSY_TO = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_valid,
   input  logic [7:0]    wr_addr,
   input  logic [7:0]    wr_data,
   output logic          wr_ready,
   input  logic          flush,
   output logic [7:0]    din,
   output logic          write,
   output logic          a0,
   input  logic          busy,
   output logic [LW-1:0] level,
   output logic          idle
);

   localparam int CW = $clog2(BUSY_TO + 1);

   wrq_state_t    st;
   jt51_entry_t   head;
   jt51_entry_t   wr_entry;
   logic [7:0]    h_addr;
   logic [7:0]    h_data;
   logic [7:0]    last_addr;
   logic          last_valid;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;
   logic          same;

   assign wr_ready = (level != LW'(DEPTH)) && !flush;
   assign push     = wr_valid && wr_ready;
   assign pop      = (st == ST_IDLE) && (level != '0) && !flush && !busy;
   assign same     = last_valid && (head.addr == last_addr);
   assign idle     = (st == ST_IDLE) && (level == '0);
   assign wr_entry = '{addr: wr_addr, data: wr_data};

   jt51_wrq_fifo #(
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (pop),
      .head     (head),
      .level    (level)
   );

   // bus sequencer: strobes are registered on the transition into each phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= ST_IDLE;
         din        <= '0;
         write      <= 1'b0;
         a0         <= 1'b0;
         h_addr     <= '0;
         h_data     <= '0;
         last_addr  <= '0;
         last_valid <= 1'b0;
         cnt        <= '0;
      end else begin
         unique case (st)
            ST_IDLE: begin
               if (pop) begin
                  h_addr <= head.addr;
                  h_data <= head.data;
                  write  <= 1'b1;
                  if (same) begin
                     st  <= ST_DATA;
                     a0  <= 1'b1;
                     din <= head.data;
                  end else begin
                     st  <= ST_ADDR;
                     a0  <= 1'b0;
                     din <= head.addr;
                  end
               end
            end
            ST_ADDR: begin
               write      <= 1'b0;
               last_addr  <= h_addr;
               last_valid <= 1'b1;
               st         <= ST_GAP;
            end
            ST_GAP: begin
               write <= 1'b1;
               a0    <= 1'b1;
               din   <= h_data;
               st    <= ST_DATA;
            end
            ST_DATA: begin
               write <= 1'b0;
               cnt   <= '0;
               st    <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (busy || cnt == CW'(BUSY_TO)) st <= ST_WAIT_LO;
               else cnt <= cnt + 1'b1;
            end
            ST_WAIT_LO: begin
               if (!busy) st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
         if (flush) last_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jt51_wrq.sv
// Directed/random bench for jt51_wrq.
// Strobes are compared with a transaction-level model of the queue.
module tb_jt51_wrq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       flush;
   logic [7:0] din;
   logic       write;
   logic       a0;
   logic       busy;
   logic [4:0] level;
   logic       idle;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int bmode = 0;
   int bcnt  = 0;
   logic wa;
   logic pw = 1'b0;

   logic [8:0] expq[$];
   logic [8:0] obsq[$];
   int         scyc[$];
   int         dcyc[$];

   logic       mlv = 1'b0;
   logic [7:0] mla = '0;

   int acc_cyc;
   int idle_cyc;
   int c0;

   jt51_wrq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .flush    (flush),
      .din      (din),
      .write    (write),
      .a0       (a0),
      .busy     (busy),
      .level    (level),
      .idle     (idle)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // register-block busy: high for 32 clocks after each data write edge
   always @(posedge clk) begin
      wa = write && a0;
      #1;
      if (bmode == 1) busy = 1'b1;
      else if (bmode == 2) busy = 1'b0;
      else begin
         if (wa) bcnt = 32;
         else if (bcnt > 0) bcnt = bcnt - 1;
         busy = (bcnt != 0);
      end
   end

   // strobe monitor
   always @(negedge clk) begin
      if (rst_n && write) begin
         chk("strobe_pulse", {31'd0, pw}, 32'd0);
         chk("strobe_busy", {31'd0, busy}, 32'd0);
         obsq.push_back({a0, din});
         scyc.push_back(cyc);
         if (a0) dcyc.push_back(cyc);
      end
      pw = write;
   end

   function automatic void model_issue(input logic [7:0] a,
                                       input logic [7:0] d);
      if (!mlv || mla != a) expq.push_back({1'b0, a});
      expq.push_back({1'b1, d});
      mlv = 1'b1;
      mla = a;
   endfunction

   task automatic cmp(input string tag);
      chk({tag, "_count"}, obsq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < obsq.size(); i++)
         chk($sformatf("%s_%0d", tag, i), obsq[i], expq[i]);
      obsq.delete();
      expq.delete();
      scyc.delete();
      dcyc.delete();
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_addr  = a;
      wr_data  = d;
      wr_valid = 1'b1;
   endtask

   task automatic wait_accept();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (i > 0) @(negedge clk);
         if (wr_ready) begin
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
            acc_cyc  = cyc;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) wr_valid = 1'b0;
      chk("push_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] d);
      drive(a, d);
      wait_accept();
   endtask

   task automatic wait_idle(input int lim);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (idle) begin
            ok = 1'b1;
            idle_cyc = cyc;
            break;
         end
      end
      chk("idle_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_dstrobe();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (write && a0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("dstrobe_timeout", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      logic [7:0] fa [5];
      logic [7:0] fd [5];
      logic [7:0] sa [17];
      logic [7:0] sd [17];
      logic [7:0] ra;
      logic [7:0] rd;

      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      flush    = 1'b0;
      busy     = 1'b0;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_din", din, 0);
      chk("rst_write", write, 0);
      chk("rst_a0", a0, 0);
      chk("rst_level", level, 0);
      chk("rst_idle", idle, 1);
      chk("rst_ready", wr_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", idle, 1);

      // single entry, cycle-exact phases
      push(8'h28, 8'h4A);
      c0 = acc_cyc;
      chk("single_level", level, 1);
      model_issue(8'h28, 8'h4A);
      wait_idle(200);
      chk("single_idle_cyc", idle_cyc, c0 + 37);
      if (scyc.size() >= 2) begin
         chk("single_addr_cyc", scyc[0], c0 + 1);
         chk("single_data_cyc", scyc[1], c0 + 3);
      end
      cmp("single");

      // repeated address skips the address phase
      push(8'h60, 8'h10);
      push(8'h60, 8'h11);
      model_issue(8'h60, 8'h10);
      model_issue(8'h60, 8'h11);
      wait_idle(300);
      cmp("repeat");

      // saturation with busy held high
      bmode = 1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 17; i++) begin
         sa[i] = 8'($urandom_range(0, 3));
         sd[i] = 8'($urandom);
      end
      for (int i = 0; i < 16; i++) push(sa[i], sd[i]);
      @(negedge clk);
      chk("sat_level", level, 16);
      chk("sat_ready", wr_ready, 0);
      drive(sa[16], sd[16]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("sat_hold_ready", wr_ready, 0);
      end
      bmode = 0;
      wait_accept();
      for (int i = 0; i < 17; i++) model_issue(sa[i], sd[i]);
      wait_idle(2000);
      cmp("sat");

      // flush during data phase of the first of five
      bmode = 1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         fa[i] = {4'(i + 1), 4'($urandom)};
         fd[i] = 8'($urandom);
         push(fa[i], fd[i]);
      end
      @(negedge clk);
      chk("flush_level_pre", level, 5);
      bmode = 0;
      wait_dstrobe();
      flush = 1'b1;
      #1;
      chk("flush_ready", wr_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_level", level, 0);
      model_issue(fa[0], fd[0]);
      mlv = 1'b0;
      wait_idle(300);
      cmp("flush");
      rd = 8'($urandom);
      push(fa[0], rd);
      model_issue(fa[0], rd);
      wait_idle(300);
      cmp("flush_readdr");

      // busy tied low: timeout pacing
      bmode = 1;
      repeat (2) @(posedge clk);
      ra = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         rd = 8'($urandom);
         push(ra, rd);
         model_issue(ra, rd);
      end
      bmode = 2;
      wait_idle(300);
      for (int i = 1; i < dcyc.size(); i++)
         chk($sformatf("to_gap_%0d", i), dcyc[i] - dcyc[i-1], 7);
      chk("to_nstrobes", dcyc.size(), 4);
      cmp("timeout");
      bmode = 0;

      // reset during data phase
      bmode = 1;
      repeat (2) @(posedge clk);
      ra = 8'($urandom);
      rd = 8'($urandom);
      push(ra, rd);
      push(ra + 8'd1, 8'($urandom));
      bmode = 0;
      wait_dstrobe();
      model_issue(ra, rd);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_write", write, 0);
      chk("arst_din", din, 0);
      chk("arst_a0", a0, 0);
      chk("arst_level", level, 0);
      chk("arst_idle", idle, 1);
      chk("arst_ready", wr_ready, 1);
      cmp("arst_pre");
      mlv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_idle_rel", idle, 1);
      repeat (10) @(negedge clk);
      cmp("arst_quiet");
      rd = 8'($urandom);
      push(ra, rd);
      model_issue(ra, rd);
      wait_idle(300);
      cmp("arst_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jt51_wrq.md
# jt51_wrq

Host write queue for the JT51 core. Sits directly upstream of the memory-mapped register block: it accepts complete (register address, data) pairs from the host over a valid/ready handshake and buffers them in a FIFO. It replays each pair as the two-phase `write`/`a0`/`din` bus sequence the register block expects, pacing every data write on that block's `busy` output. The host never has to poll busy or sequence a0 itself.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `LW`, $clog2(DEPTH)+1: width of `level`; derived, not overridden.
- `BUSY_TO`, 3: clocks to wait for `busy` to rise after a data write before giving up.

Ports:
- `clk` in 1: core clock, same clock as the register block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_valid` in 1: host offers an entry.
- `wr_addr` in 8: register address.
- `wr_data` in 8: register data.
- `wr_ready` out 1: entry accepted on a clock where `wr_valid && wr_ready`.
- `flush` in 1: discard all queued entries.
- `din` out 8: register-block data bus.
- `write` out 1: register-block write strobe.
- `a0` out 1: 0 = address phase, 1 = data phase.
- `busy` in 1: register-block busy.
- `level` out LW: number of queued entries, 0..DEPTH.
- `idle` out 1: FSM in IDLE and `level==0`.

## Operation
- FIFO push occurs on `wr_valid && wr_ready`.
- `wr_ready = (level != DEPTH) && !flush`.
- Pop occurs when the FSM leaves IDLE. The popped entry is latched into hold registers `h_addr`/`h_data`.
- FSM states, in order:
  - IDLE: if `level != 0` and `!flush`, pop. If `last_valid && head.addr == last_addr`, go to DATA; otherwise go to ADDR.
  - ADDR: drive `write=1`, `a0=0`, `din=h_addr`. Set `last_addr <= h_addr` and `last_valid <= 1`. Go to GAP.
  - GAP: drive `write=0`. Go to DATA.
  - DATA: drive `write=1`, `a0=1`, `din=h_data`. Go to WAIT_HI.
  - WAIT_HI: drive `write=0`. Go to WAIT_LO when `busy==1`, or when the timeout counter reaches BUSY_TO.
  - WAIT_LO: go to IDLE when `busy==0`.
- `write` is high for exactly one clock per phase and is low between phases, so the register block sees a clean 0→1 edge on every data write.
- All bus outputs are registered. `din` and `a0` hold their last value while `write==0`.
- Push and pop in the same clock leave `level` unchanged.
- `flush` clears `level` to 0 and clears `last_valid` on the next edge. The entry already in the hold registers completes its transaction; entries still in the FIFO are never issued. `flush` takes precedence over a simultaneous push, which is not accepted because `wr_ready` is 0.
- When `level==DEPTH`, `wr_ready` is 0 and the host must hold its entry.
- If `busy` is already high when the FSM reaches IDLE, no new transaction starts until `busy` is low: IDLE additionally requires `busy==0`.
- Reset values: `din=0`, `write=0`, `a0=0`, `level=0`, `idle=1`, `wr_ready=1`, FSM=IDLE, `last_valid=0`, `last_addr=0`, timeout counter 0.
- Reset mid-transaction drops `write` immediately (asynchronous) and discards the hold registers and the FIFO.

## Timing
- Entry accepted at edge E0:
  - `level=1` after E0.
  - IDLE pops at E1; ADDR outputs are valid during E1–E2.
  - GAP during E2–E3.
  - DATA during E3–E4.
  - `busy` rises after E4; WAIT_HI exits at E5.
  - `idle` is 1 again one clock after `busy` falls.
- Repeated address skips ADDR and GAP: data strobe during E1–E2.
- Back-to-back entries: the next pop happens on the first IDLE clock after `busy` falls. There are no extra bubbles.
- Throughput is bounded by the register block's 32-cen busy period. For a single entry, `level` peaks at 1.

## Structure
- Shared package `jt51_pkg`: FSM state encoding (IDLE, ADDR, GAP, DATA, WAIT_HI, WAIT_LO) and the `jt51_entry_t` {addr[7:0], data[7:0]} type.
- Sub-module `jt51_wrq_fifo`: synchronous single-clock FIFO, DEPTH×16, with push/pop/flush, `level` and first-word-fall-through head. The top level holds the FSM, hold registers, last-address tracker and timeout counter.

## Test plan
- Single entry {0x28, 0x4A}, `busy` modelled as 32 cen after the write edge:
  - Response: ADDR strobe with `din=0x28`, `a0=0`; one GAP clock; DATA strobe with `din=0x4A`, `a0=1`; `idle` returns after `busy` falls.
- Entries {0x60, 0x10} then {0x60, 0x11}:
  - Response: the second entry issues only a data strobe (no ADDR phase); data 0x11 waits for the first `busy` to fall.
- Push DEPTH+1 entries with `busy` held high:
  - Response: `level` saturates at 16, `wr_ready=0` on the 17th, and it is accepted once the FSM pops.
- Queue 5 entries, assert `flush` during DATA of the first:
  - Response: the first completes, `level=0` next clock, no further strobes, and the next entry re-issues its ADDR phase.
- `busy` tied low:
  - Response: WAIT_HI times out after 3 clocks and the queue keeps draining at 7 clocks per entry.
- `rst_n` asserted during DATA:
  - Response: `write` drops asynchronously, all outputs take reset values, and `idle=1` after release.
